// File: rtl/scan_window_arb.sv
// Per-channel Tscan slot counters with optional interlaced window, plus a 3-state scan-receiver arbiter.
// Window outputs lag the slot counter by one clk; the grant is held until the window or response phase ends (no preemption).
module scan_window_arb #(
  parameter int NCH      = 2,
  parameter int CNT_W    = 16,
  parameter int TO_SLOTS = 8,
  parameter int TO_W     = 4
) (
  input  logic               clk_6M,
  input  logic               rstz,
  input  logic               tslot_p,
  input  logic [NCH-1:0]     scan_en,
  input  logic [NCH*CNT_W-1:0] regi_interval,
  input  logic [NCH*CNT_W-1:0] regi_window,
  input  logic [NCH-1:0]     regi_interlace,
  input  logic               corr_hit,
  input  logic               resp_done,
  output logic [NCH-1:0]     win,
  output logic [NCH-1:0]     win_endp,
  output logic [NCH-1:0]     win_2nd,
  output logic [NCH-1:0]     scan_gnt,
  output logic [1:0]         state,
  output logic               resp_to
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_SLOTS - 1);

  logic [NCH-1:0]  raw;
  logic [NCH-1:0]  second;
  logic [NCH-1:0]  win_q;
  logic [NCH-1:0]  win_2nd_q;
  logic [NCH-1:0]  gnt_q;
  logic [NCH-1:0]  pick;
  logic [TO_W-1:0] to_cnt_q;
  logic            resp_to_q;
  state_e          state_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CNT_W-1:0] iv;
    logic [CNT_W-1:0] wd;
    logic [CNT_W:0]   wd2;
    logic [CNT_W:0]   eff;
    logic             ilv;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign iv  = regi_interval[k*CNT_W +: CNT_W];
    assign wd  = regi_window[k*CNT_W +: CNT_W];
    // Doubled window is computed one bit wider so it can never wrap.
    assign wd2 = {wd, 1'b0};
    assign ilv = regi_interlace[k] && ({1'b0, iv} >= wd2);
    assign eff = ilv ? wd2 : {1'b0, wd};

    assign raw[k]    = scan_en[k] && ({1'b0, cnt_q} < eff);
    assign second[k] = raw[k] && ilv && (cnt_q >= wd);

    always_comb begin
      cnt_d = cnt_q;
      if (!scan_en[k]) begin
        cnt_d = '0;
      end else if (tslot_p) begin
        cnt_d = (cnt_q >= iv) ? '0 : cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      win_q     <= '0;
      win_2nd_q <= '0;
    end else begin
      win_q     <= raw;
      win_2nd_q <= second;
    end
  end

  // Isolate the lowest set bit: index 0 has highest priority.
  assign pick = win_q & (~win_q + NCH'(1));

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      to_cnt_q  <= '0;
      resp_to_q <= 1'b0;
    end else begin
      resp_to_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|win_q) begin
            state_q <= ST_SCAN;
            gnt_q   <= pick;
          end
        end
        ST_SCAN: begin
          if (corr_hit) begin
            state_q  <= ST_RESP;
            to_cnt_q <= '0;
          end else if (!(|(win_q & gnt_q))) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
          end
        end
        ST_RESP: begin
          // A completed exchange or a disabled channel both end quietly, ahead of any timeout.
          if (resp_done || !(|(scan_en & gnt_q))) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
          end else if (tslot_p) begin
            if (to_cnt_q == TO_LAST) begin
              state_q   <= ST_IDLE;
              gnt_q     <= '0;
              resp_to_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign win      = win_q;
  assign win_2nd  = win_2nd_q;
  assign win_endp = ~raw & win_q;
  assign scan_gnt = gnt_q;
  assign state    = state_q;
  assign resp_to  = resp_to_q;

endmodule
